box_target_driver: RTL and testbench

Output-side counterpart to the box sensor path in the whack-a-box game. On each round request it pseudo-randomly selects a target box and lights that box's lamp through a GPIO drive bus. It then watches the synchronized, debounced box-hit address returned by the sensor path. It reports hit or miss to the game controller with a done pulse and keeps a saturating score.

---
 rtl/bytebasher_pkg.sv | 11 +
 rtl/box_hit_debounce.sv | 37 +++
 rtl/box_target_driver.sv | 81 ++++++++
 tb/tb_box_target_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bytebasher_pkg.sv
// bytebasher_pkg: shared types and constants for the whack-a-box lamp/sensor path
package bytebasher_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_PICK, ST_ACTIVE, ST_RESULT, ST_WAIT_RELEASE} state_t;
  localparam int BOX_ADDR_W = 3;
  localparam logic [BOX_ADDR_W-1:0] NO_CONTACT = 3'd0;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/box_hit_debounce.sv
// box_hit_debounce: 2-flop synchronizer plus stability counter for the sensor box address
module box_hit_debounce
  import bytebasher_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BOX_ADDR_W-1:0] hit_box,
  output logic [BOX_ADDR_W-1:0] stable_box
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [BOX_ADDR_W-1:0] r_sync1, r_sync2, r_cand;
  logic [CW-1:0] r_cnt;
  // r_cnt holds how many consecutive samples of r_cand have been seen so far
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= NO_CONTACT;
      r_sync2 <= NO_CONTACT;
      r_cand <= NO_CONTACT;
      r_cnt <= '0;
      stable_box <= NO_CONTACT;
    end else begin
      r_sync1 <= hit_box;
      r_sync2 <= r_sync1;
      if (r_sync2 == stable_box) r_cnt <= '0;
      else if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        if (DEBOUNCE_CYCLES <= 1) stable_box <= r_sync2;
        else r_cnt <= CW'(1);
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_box <= r_sync2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/box_target_driver.sv
// box_target_driver: lights a pseudo-random box per round, judges the debounced
// contact as hit/miss/timeout and keeps a saturating score
module box_target_driver
  import bytebasher_pkg::*;
#(
  parameter int         NUM_BOXES       = 4,
  parameter int         WINDOW_CYCLES   = 50_000_000,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BOX_ADDR_W-1:0] hit_box,
  output logic [NUM_BOXES-1:0]  gpio_out,
  output logic [BOX_ADDR_W-1:0] target_box,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [7:0]            score
);
  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(WINDOW_CYCLES - 1);
  localparam logic [BOX_ADDR_W-1:0] MAX_BOX = BOX_ADDR_W'(NUM_BOXES);
  state_t r_state, w_next;
  logic [7:0] r_lfsr;
  logic [TW-1:0] r_timer;
  logic [BOX_ADDR_W-1:0] w_stable, w_cand, w_target;
  logic w_accept, w_hit;
  box_hit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk(clk),
    .reset(reset),
    .hit_box(hit_box),
    .stable_box(w_stable)
  );
  assign w_cand = r_lfsr[BOX_ADDR_W-1:0];
  assign w_accept = w_cand != NO_CONTACT && w_cand <= MAX_BOX && w_cand != target_box;
  assign w_target = (r_state == ST_PICK && w_accept) ? w_cand : target_box;
  // any contact outranks the timeout; a wrong box is simply a miss
  always_comb begin
    w_next = r_state;
    w_hit = 1'b0;
    case (r_state)
      ST_IDLE: w_next = start ? ST_PICK : ST_IDLE;
      ST_PICK: w_next = w_accept ? ST_ACTIVE : ST_PICK;
      ST_ACTIVE: begin
        w_hit = w_stable == target_box;
        w_next = (w_stable != NO_CONTACT || r_timer == LAST_TICK) ? ST_RESULT : ST_ACTIVE;
      end
      ST_RESULT: w_next = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE: w_next = (w_stable == NO_CONTACT) ? ST_IDLE : ST_WAIT_RELEASE;
      default: w_next = ST_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lfsr <= LFSR_SEED;
      r_timer <= '0;
      target_box <= NO_CONTACT;
      gpio_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hit <= 1'b0;
      score <= 8'd0;
    end else begin
      r_state <= w_next;
      r_lfsr <= lfsr_step(r_lfsr);
      r_timer <= (r_state == ST_ACTIVE && w_next == ST_ACTIVE) ? r_timer + 1'b1 : '0;
      target_box <= w_target;
      gpio_out <= (w_next == ST_ACTIVE) ? NUM_BOXES'(1) << (w_target - 1'b1) : '0;
      busy <= w_next != ST_IDLE;
      done <= w_next == ST_RESULT;
      if (w_next == ST_RESULT) begin
        hit <= w_hit;
        score <= score + {7'd0, w_hit && score != 8'hFF};
      end
    end
  end
endmodule

// File: tb/tb_box_target_driver.sv
// tb_box_target_driver: randomized rounds scored by a queue-based scoreboard and game-rule model
module tb_box_target_driver;
  logic clk = 1'b0, reset, start;
  logic [2:0] hit_box;
  logic [3:0] gpio_out;
  logic [2:0] target_box;
  logic busy, done, hit;
  logic [7:0] score;
  typedef struct {bit hit; int score; int cyc; int lit;} exp_t;
  exp_t q[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, lit = 0, sc = 0, prev = 0;

  box_target_driver #(.NUM_BOXES(4), .WINDOW_CYCLES(100), .DEBOUNCE_CYCLES(4), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .start(start), .hit_box(hit_box), .gpio_out(gpio_out),
    .target_box(target_box), .busy(busy), .done(done), .hit(hit), .score(score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // monitor: lamp-on duration and every done pulse are checked against the queue
  always @(negedge clk) begin
    if (reset) lit = 0;
    else if (gpio_out != 0) lit = lit + 1;
    if (done) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        check("done_hit", hit, me.hit);
        check("done_score", score, me.score);
        check("done_lamp_off", gpio_out, 0);
        check("done_cycle", cyc, me.cyc);
        check("lamp_cycles", lit, me.lit);
      end
      lit = 0;
    end
  end

  task automatic wait_lamp(output int box);
    box = 0;
    for (int i = 0; i < 300 && gpio_out == 0; i++) tick;
    check("lamp_on", gpio_out != 0, 1);
    check("lamp_onehot", $onehot(gpio_out), 1);
    for (int k = 0; k < 4; k++) if (gpio_out[k]) box = k + 1;
  endtask

  // mode 0 = press lit box, 1 = press another box, 2 = never press
  task automatic play(input int mode, input int dly, input bit hold);
    int g, box;
    exp_t e;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_lamp(box);
    g = cyc;
    check("target_matches_lamp", target_box, box);
    check("target_in_range", box >= 1 && box <= 4, 1);
    if (prev != 0) check("target_no_repeat", box != prev, 1);
    prev = box;
    e.hit = mode == 0;
    sc = (sc + int'(e.hit) > 255) ? 255 : sc + int'(e.hit);
    e.score = sc;
    if (mode == 2) e.cyc = g + 100;
    else begin
      repeat (dly) tick;
      hit_box = (mode == 0) ? 3'(box) : 3'(box % 4 + 1);
      e.cyc = cyc + 7;
    end
    e.lit = e.cyc - g;
    q.push_back(e);
    for (int i = 0; i < 150 && !done; i++) tick;
    check("done_seen", done, 1);
    if (!hold) begin
      hit_box = 3'd0;
      for (int i = 0; i < 30 && busy; i++) tick;
      check("busy_released", busy, 0);
    end
  endtask

  task automatic hold_test;
    int r;
    play(0, 5, 1'b1);
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (8) tick;
    check("hold_busy", busy, 1);
    check("hold_lamp_off", gpio_out, 0);
    hit_box = 3'd0;
    r = cyc;
    repeat (6) tick;
    check("release_busy_6", busy, 1);
    tick;
    check("release_busy_7", busy, 0);
    repeat (5) tick;
    check("start_not_queued", busy, 0);
  endtask

  initial begin
    int box;
    reset = 1'b1;
    start = 1'b0;
    hit_box = 3'd0;
    repeat (3) tick;
    start = 1'b1;
    repeat (3) tick;
    check("start_in_reset", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (10) tick;
    check("rst_gpio", gpio_out, 0);
    check("rst_target", target_box, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_score", score, 0);
    play(0, 5, 1'b0);
    play(2, 0, 1'b0);
    play(1, 5, 1'b0);
    hold_test();
    repeat (20) play(int'($urandom_range(0, 2)), int'($urandom_range(1, 60)), 1'b0);
    for (int i = 0; i < 256; i++) play(0, int'($urandom_range(1, 10)), 1'b0);
    check("score_saturated", score, 255);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_lamp(box);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    check("midreset_gpio", gpio_out, 0);
    check("midreset_busy", busy, 0);
    reset = 1'b0;
    sc = 0;
    prev = 0;
    check("midreset_score", score, 0);
    check("midreset_target", target_box, 0);
    repeat (130) tick;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
